// File: rtl/debounced_edge_detector.sv
// debounced_edge_detector
// Multi-channel push-button/switch conditioner. Each channel is synchronised,
// debounced (a new level is accepted only after DB_CYCLES consecutive stable
// cycles), and then produces registered one-cycle rise/fall pulses.
// Optional feature macro: EDGE_STICKY_EN adds per-channel sticky edge flags
// (p_sticky/n_sticky) cleared by sticky_clr; set wins over a simultaneous clear.
module debounced_edge_detector #(
  parameter int CH          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CH-1:0] level_in,
`ifdef EDGE_STICKY_EN
  input  logic [CH-1:0] sticky_clr,
  output logic [CH-1:0] p_sticky,
  output logic [CH-1:0] n_sticky,
`endif
  output logic [CH-1:0] level_o,
  output logic [CH-1:0] p_edge,
  output logic [CH-1:0] n_edge,
  output logic [CH-1:0] edge_o,
  output logic          any_edge
);

  localparam int             CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] s;
  logic [CW-1:0] cnt_q  [CH];
  logic [CW-1:0] cnt_d  [CH];
  logic [CH-1:0] level_q, level_d;
  logic [CH-1:0] level_dly_q;
  logic [CH-1:0] p_edge_q, n_edge_q;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the raw pins, last stage feeds the debouncer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= level_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Debounce next-state: count while the synchronised input disagrees with the
  // accepted level; accept on the DB_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < CH; i++) begin
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i]   = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounce state registers; a reset mid-count discards the partial count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
      level_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Edge pulses registered from the accepted level and its one-cycle delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_dly_q <= '0;
      p_edge_q    <= '0;
      n_edge_q    <= '0;
    end else begin
      level_dly_q <= level_q;
      p_edge_q    <= level_q & ~level_dly_q;
      n_edge_q    <= ~level_q & level_dly_q;
    end
  end

  assign level_o  = level_q;
  assign p_edge   = p_edge_q;
  assign n_edge   = n_edge_q;
  assign edge_o   = p_edge_q | n_edge_q;
  assign any_edge = |edge_o;

`ifdef EDGE_STICKY_EN
  logic [CH-1:0] p_sticky_q, p_sticky_d;
  logic [CH-1:0] n_sticky_q, n_sticky_d;

  // Sticky flags: a pulse sets the bit even if a clear arrives in the same cycle.
  always_comb begin
    p_sticky_d = p_edge_q | (p_sticky_q & ~sticky_clr);
    n_sticky_d = n_edge_q | (n_sticky_q & ~sticky_clr);
  end

  // Sticky flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_sticky_q <= '0;
      n_sticky_q <= '0;
    end else begin
      p_sticky_q <= p_sticky_d;
      n_sticky_q <= n_sticky_d;
    end
  end

  assign p_sticky = p_sticky_q;
  assign n_sticky = n_sticky_q;
`endif

endmodule
